// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// interrupt_controller_pkg : shared constants and state type for the IRQ block
// Revision: 1.0
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

  localparam int NUM_IRQ_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/irq_priority_enc.sv
// ============================================================================
// irq_priority_enc : combinational fixed-priority encoder, lowest index wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module irq_priority_enc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req,
  output logic [2:0]       idx,
  output logic             valid
);

  always_comb begin
    idx   = 3'd0;
    valid = |req;
    // Scan downward so the lowest set index is the last assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller : rising-edge capture, maskable fixed-priority IRQ
// presentation with ack handshake and a one-cycle holdoff. Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] int_in,
  input  logic [NUM_IRQ-1:0] mask_value,
  input  logic               mask_write,
  input  logic               ack,
  output logic               irq,
  output logic [2:0]         irq_id,
  output logic [NUM_IRQ-1:0] pending
);

  irq_state_e         state_q, state_d;
  logic               irq_q, irq_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] sample_q, sample_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [2:0]         enc_idx;
  logic               enc_valid;

  irq_priority_enc #(
    .WIDTH (NUM_IRQ)
  ) u_enc (
    .req   (pending_q & mask_q),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    rise      = int_in & ~sample_q;
    sample_d  = int_in;
    mask_d    = mask_write ? mask_value : mask_q;
    id_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_onehot[i] = (irq_id_q == 3'(i));
    end

    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    clr      = '0;

    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d  = PRESENT;
          irq_d    = 1'b1;
          irq_id_d = enc_idx;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr     = id_onehot;
          irq_d   = 1'b0;
          state_d = HOLDOFF;
        end
      end
      HOLDOFF: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

    // A fresh edge on the acked source outranks the clear.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      irq_id_q  <= 3'd0;
      pending_q <= '0;
      sample_q  <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
      mask_q    <= mask_d;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// tb_interrupt_controller : directed vectors with a cycle-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] int_in = 8'h00;
  logic [7:0] mask_value = 8'h00;
  logic       mask_write = 1'b0;
  logic       ack = 1'b0;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .int_in     (int_in),
    .mask_value (mask_value),
    .mask_write (mask_write),
    .ack        (ack),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  // Reference model: "busy" means a source is being presented; "gap" counts
  // cycles after an ack during which no new selection may happen.
  typedef struct {
    bit [7:0] pend;
    bit [7:0] prev;
    bit [7:0] msk;
    bit       busy;
    int       cur;
    int       gap;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.pend = 8'h00; r.prev = 8'h00; r.msk = 8'hFF;
    r.busy = 1'b0;  r.cur = 0;      r.gap = 0;
    return r;
  endfunction

  function automatic model_t model_next(model_t s, logic [7:0] in, logic a,
                                        logic mw, logic [7:0] mv);
    model_t n = s;
    int sel = -1;
    if (s.busy) begin
      if (a) begin
        n.pend[s.cur] = 1'b0;
        n.busy = 1'b0;
        n.gap  = 1;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else begin
      for (int i = 7; i >= 0; i--)
        if (s.pend[i] && s.msk[i]) sel = i;
      if (sel >= 0) begin
        n.busy = 1'b1;
        n.cur  = sel;
      end
    end
    n.pend = n.pend | (in & ~s.prev);
    n.prev = in;
    if (mw) n.msk = mv;
    return n;
  endfunction

  model_t m = model_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_next(m, int_in, ack, mask_write, mask_value);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_irq", int'(irq), int'(m.busy));
    check("model_pending", int'(pending), int'(m.pend));
    if (m.busy) check("model_irq_id", int'(irq_id), m.cur);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] v);
    int_in = v;
    cyc(1);
    int_in = 8'h00;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    cyc(2);
    check("reset_irq", int'(irq), 0);
    check("reset_irq_id", int'(irq_id), 0);
    check("reset_pending", int'(pending), 8'h00);
    reset = 1'b1;
    cyc(2);

    // Single pulse on source 3
    pulse(8'h08);
    check("t31_pend", int'(pending), 8'h08);
    check("t31_irq_early", int'(irq), 0);
    cyc(1);
    check("t31_irq", int'(irq), 1);
    check("t31_id", int'(irq_id), 3);
    do_ack();
    check("t31_hold_irq", int'(irq), 0);
    check("t31_clear", int'(pending), 8'h00);
    cyc(3);

    // Simultaneous 5 and 1
    pulse(8'h22);
    check("t32_pend", int'(pending), 8'h22);
    cyc(1);
    check("t32_first", int'(irq_id), 1);
    do_ack();
    check("t32_hold", int'(irq), 0);
    check("t32_pend2", int'(pending), 8'h20);
    cyc(2);
    check("t32_second_irq", int'(irq), 1);
    check("t32_second", int'(irq_id), 5);
    do_ack();
    cyc(3);

    // Masked capture, then unmask
    mask_value = 8'hFE; mask_write = 1'b1;
    cyc(1);
    mask_write = 1'b0;
    pulse(8'h01);
    check("t33_pend", int'(pending), 8'h01);
    cyc(3);
    check("t33_masked", int'(irq), 0);
    mask_value = 8'hFF; mask_write = 1'b1;
    cyc(1);
    mask_write = 1'b0;
    check("t33_not_yet", int'(irq), 0);
    cyc(1);
    check("t33_irq", int'(irq), 1);
    check("t33_id", int'(irq_id), 0);
    do_ack();
    cyc(3);

    // New edge on the acked source during ack
    pulse(8'h10);
    cyc(1);
    check("t34_id", int'(irq_id), 4);
    ack = 1'b1; int_in = 8'h10;
    cyc(1);
    ack = 1'b0; int_in = 8'h00;
    check("t34_kept", int'(pending), 8'h10);
    check("t34_hold", int'(irq), 0);
    cyc(2);
    check("t34_again", int'(irq), 1);
    check("t34_again_id", int'(irq_id), 4);
    do_ack();
    cyc(3);

    // No preemption by a higher-priority arrival
    pulse(8'h40);
    cyc(1);
    check("t35_id6", int'(irq_id), 6);
    pulse(8'h04);
    cyc(1);
    check("t35_stays", int'(irq_id), 6);
    check("t35_pend", int'(pending), 8'h44);
    do_ack();
    cyc(2);
    check("t35_next", int'(irq_id), 2);
    check("t35_next_irq", int'(irq), 1);
    do_ack();
    cyc(3);

    // Async reset mid-PRESENT, source 7 held across release
    pulse(8'h08);
    cyc(1);
    check("t36_present", int'(irq), 1);
    int_in = 8'h80;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t36_rst_irq", int'(irq), 0);
    check("t36_rst_pend", int'(pending), 8'h00);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("t36_edge", int'(pending), 8'h80);
    cyc(1);
    check("t36_id", int'(irq_id), 7);
    do_ack();
    cyc(4);
    check("t36_once_irq", int'(irq), 0);
    check("t36_once_pend", int'(pending), 8'h00);
    int_in = 8'h00;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
